cam_lookup_arb: RTL and testbench

Arbiter and sequencer that shares a single CAM (write/search ports) between NUM_REQ requesters.
Each request is a lookup, or a lookup-or-insert, on a DATA_SIZE-bit key.
- On a miss with insert, the block allocates an entry using FIFO (round-robin pointer) replacement and writes the key.
- It sits between client logic and the cam instance and is the only driver of the cam write/search inputs.

---
 rtl/cam_lookup_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_cam_lookup_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lookup_arb.sv
// Round-robin arbiter and sequencer sharing one CAM between NUM_REQ requesters.
// Lookup-or-insert with FIFO replacement; define CAM_STATS_EN for hit/miss/evict counters.
module cam_lookup_arb #(
  parameter int DATA_WIDTH = 5,
  parameter int DATA_SIZE  = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_insert,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_key,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic                         resp_hit,
  output logic [DATA_WIDTH-1:0]        resp_index,
  output logic                         resp_evict,
  output logic                         full,
  output logic                         cam_write,
  output logic [DATA_WIDTH-1:0]        cam_write_index,
  output logic [DATA_SIZE-1:0]         cam_write_data,
  output logic                         cam_search,
  output logic [DATA_SIZE-1:0]         cam_search_data,
  input  logic [DATA_WIDTH-1:0]        cam_search_index,
  input  logic                         cam_search_valid
`ifdef CAM_STATS_EN
  ,
  output logic [15:0]                  stat_hits,
  output logic [15:0]                  stat_misses,
  output logic [15:0]                  stat_evicts
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [DATA_WIDTH:0] DEPTH = {1'b1, {DATA_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    WRITE,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         grant;
  logic [DATA_SIZE-1:0]  op_key;
  logic                  op_insert;
  logic                  res_hit;
  logic [DATA_WIDTH-1:0] res_index;
  logic                  res_evict;
  logic [DATA_WIDTH-1:0] alloc_ptr;
  logic [DATA_WIDTH:0]   occupancy;
  logic                  is_full;

  logic                  any_req;
  logic [GW-1:0]         pick;
  logic [DATA_SIZE-1:0]  pick_key;
  logic                  pick_insert;

  assign is_full = (occupancy == DEPTH);
  assign full    = is_full;

  // Scan downward from the farthest offset so the first set bit at or after rr_ptr wins.
  always_comb begin
    int cand;
    any_req = 1'b0;
    pick    = '0;
    cand    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        any_req = 1'b1;
        pick    = GW'(cand);
      end
    end
  end

  always_comb begin
    pick_key    = '0;
    pick_insert = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        pick_key    = req_key[i*DATA_SIZE +: DATA_SIZE];
        pick_insert = req_insert[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = SEARCH;
        end
      end
      SEARCH: state_next = CHECK;
      CHECK: begin
        if (cam_search_valid) begin
          state_next = RESP;
        end else if (op_insert) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operation context and allocation state; result fields are staged here for the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      op_key    <= '0;
      op_insert <= 1'b0;
      res_hit   <= 1'b0;
      res_index <= '0;
      res_evict <= 1'b0;
      alloc_ptr <= '0;
      occupancy <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            op_key    <= pick_key;
            op_insert <= pick_insert;
            res_hit   <= 1'b0;
            res_index <= '0;
            res_evict <= 1'b0;
          end
        end
        CHECK: begin
          if (cam_search_valid) begin
            res_hit   <= 1'b1;
            res_index <= cam_search_index;
          end else if (!op_insert) begin
            res_hit   <= 1'b0;
            res_index <= '1;
          end
        end
        WRITE: begin
          res_index <= alloc_ptr;
          res_evict <= is_full;
          alloc_ptr <= alloc_ptr + 1'b1;
          if (!is_full) begin
            occupancy <= occupancy + 1'b1;
          end
        end
        RESP: begin
          if (grant == GW'(NUM_REQ - 1)) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_valid      = '0;
    resp_hit        = 1'b0;
    resp_index      = '0;
    resp_evict      = 1'b0;
    cam_write       = 1'b0;
    cam_write_index = '0;
    cam_write_data  = '0;
    cam_search      = 1'b0;
    cam_search_data = '0;
    case (state)
      SEARCH: begin
        cam_search      = 1'b1;
        cam_search_data = op_key;
      end
      WRITE: begin
        cam_write       = 1'b1;
        cam_write_index = alloc_ptr;
        cam_write_data  = op_key;
      end
      RESP: begin
        resp_valid[grant] = 1'b1;
        resp_hit          = res_hit;
        resp_index        = res_index;
        resp_evict        = res_evict;
      end
      default: ;
    endcase
  end

`ifdef CAM_STATS_EN
  // Every non-hit counts as a miss, inserting or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (state == RESP) begin
      if (res_hit) begin
        if (stat_hits != 16'hFFFF) begin
          stat_hits <= stat_hits + 16'd1;
        end
      end else if (stat_misses != 16'hFFFF) begin
        stat_misses <= stat_misses + 16'd1;
      end
      if (res_evict && (stat_evicts != 16'hFFFF)) begin
        stat_evicts <= stat_evicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_lookup_arb.sv
// Directed bench for cam_lookup_arb with a behavioural CAM and a queue of expected responses.
module tb_cam_lookup_arb;

  localparam int DW    = 5;
  localparam int DS    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_insert;
  logic [NR*DS-1:0] req_key;
  logic [NR-1:0]   resp_valid;
  logic            resp_hit;
  logic [DW-1:0]   resp_index;
  logic            resp_evict;
  logic            full;
  logic            cam_write;
  logic [DW-1:0]   cam_write_index;
  logic [DS-1:0]   cam_write_data;
  logic            cam_search;
  logic [DS-1:0]   cam_search_data;
  logic [DW-1:0]   cam_search_index;
  logic            cam_search_valid;

  cam_lookup_arb #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .NUM_REQ(NR)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_insert       (req_insert),
    .req_key          (req_key),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_index       (resp_index),
    .resp_evict       (resp_evict),
    .full             (full),
    .cam_write        (cam_write),
    .cam_write_index  (cam_write_index),
    .cam_write_data   (cam_write_data),
    .cam_search       (cam_search),
    .cam_search_data  (cam_search_data),
    .cam_search_index (cam_search_index),
    .cam_search_valid (cam_search_valid)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: result one cycle after search, lowest matching index wins.
  logic [DS-1:0]    cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_live;

  always @(posedge clk) begin
    if (rst) begin
      cam_live         <= '0;
      cam_search_valid <= 1'b0;
      cam_search_index <= '0;
    end else begin
      if (cam_write) begin
        cam_mem[cam_write_index]  <= cam_write_data;
        cam_live[cam_write_index] <= 1'b1;
      end
      cam_search_valid <= 1'b0;
      cam_search_index <= '0;
      if (cam_search) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (cam_live[i] && (cam_mem[i] == cam_search_data)) begin
            cam_search_valid <= 1'b1;
            cam_search_index <= DW'(i);
          end
        end
      end
    end
  end

  int            write_count = 0;
  logic [DW-1:0] last_w_idx  = '0;
  logic [DS-1:0] last_w_data = '0;
  bit            overlap_seen = 1'b0;

  always @(negedge clk) begin
    if (cam_write === 1'b1) begin
      write_count++;
      last_w_idx  = cam_write_index;
      last_w_data = cam_write_data;
    end
    if ((cam_write === 1'b1) && (cam_search === 1'b1)) begin
      overlap_seen = 1'b1;
    end
  end

  typedef struct {
    logic [NR-1:0] rv;
    logic          hit;
    logic [DW-1:0] idx;
    logic          evict;
    int            lat;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int id, input bit ins, input logic [DS-1:0] key);
    req_insert[id]       = ins;
    req_key[id*DS +: DS] = key;
    req[id]              = 1'b1;
  endtask

  task automatic expect_resp(input string tag, input int id, input bit hit, input int idx,
                             input bit evict, input int lat);
    exp_t e;
    e.rv    = NR'(1 << id);
    e.hit   = hit;
    e.idx   = DW'(idx);
    e.evict = evict;
    e.lat   = lat;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Latency counts negedges after the req-sampling edge, so it matches the cycle number.
  task automatic wait_resp();
    exp_t e;
    int   k    = 0;
    bit   seen = 1'b0;
    e = sb.pop_front();
    while (!seen && (k < 20)) begin
      @(negedge clk);
      k++;
      if (resp_valid !== '0) begin
        seen = 1'b1;
      end
    end
    check_output($sformatf("%s.seen", e.tag), 64'(seen), 64'd1);
    if (seen) begin
      check_output($sformatf("%s.valid", e.tag), 64'(resp_valid), 64'(e.rv));
      check_output($sformatf("%s.hit", e.tag), 64'(resp_hit), 64'(e.hit));
      check_output($sformatf("%s.index", e.tag), 64'(resp_index), 64'(e.idx));
      check_output($sformatf("%s.evict", e.tag), 64'(resp_evict), 64'(e.evict));
      check_output($sformatf("%s.latency", e.tag), 64'(k), 64'(e.lat));
    end
    req = req & ~e.rv;
  endtask

  task automatic single_op(input string tag, input int id, input bit ins, input logic [DS-1:0] key,
                           input bit hit, input int idx, input bit evict);
    @(negedge clk);
    apply_stimulus(id, ins, key);
    expect_resp(tag, id, hit, idx, evict, (ins && !hit) ? 4 : 3);
    wait_resp();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  wc;
    int  k;
    bit  wseen;
    rst        = 1'b1;
    req        = 2'b11;
    req_insert = '0;
    req_key    = '0;

    repeat (2) begin
      @(negedge clk);
      check_output("rst.resp_valid", 64'(resp_valid), 64'd0);
      check_output("rst.cam_write", 64'(cam_write), 64'd0);
      check_output("rst.cam_search", 64'(cam_search), 64'd0);
      check_output("rst.full", 64'(full), 64'd0);
    end
    req = '0;
    rst = 1'b0;
    @(negedge clk);
    check_output("idle.cam_search", 64'(cam_search), 64'd0);

    single_op("ins7", 0, 1'b1, 32'd7, 1'b0, 0, 1'b0);
    check_output("ins7.wcount", 64'(write_count), 64'd1);
    check_output("ins7.widx", 64'(last_w_idx), 64'd0);
    check_output("ins7.wdata", 64'(last_w_data), 64'd7);
    single_op("hit7", 1, 1'b0, 32'd7, 1'b1, 0, 1'b0);

    wc = write_count;
    single_op("miss9a", 0, 1'b0, 32'd9, 1'b0, DEPTH - 1, 1'b0);
    single_op("miss9b", 1, 1'b0, 32'd9, 1'b0, DEPTH - 1, 1'b0);
    check_output("miss.nowrite", 64'(write_count), 64'(wc));

    @(negedge clk);
    apply_stimulus(0, 1'b1, 32'd5);
    apply_stimulus(1, 1'b1, 32'd5);
    expect_resp("pair5.r0", 0, 1'b0, 1, 1'b0, 4);
    expect_resp("pair5.r1", 1, 1'b1, 1, 1'b0, 4);
    wait_resp();
    wait_resp();
    check_output("pair5.wcount", 64'(write_count), 64'(wc + 1));

    single_op("hit5", 0, 1'b0, 32'd5, 1'b1, 1, 1'b0);
    @(negedge clk);
    apply_stimulus(0, 1'b0, 32'd7);
    apply_stimulus(1, 1'b0, 32'd7);
    expect_resp("pair7.r1", 1, 1'b1, 0, 1'b0, 3);
    expect_resp("pair7.r0", 0, 1'b1, 0, 1'b0, 4);
    wait_resp();
    wait_resp();

    for (int i = 0; i < 30; i++) begin
      single_op($sformatf("fill%0d", i), 0, 1'b1, DS'(200 + i), 1'b0, 2 + i, 1'b0);
      if (i == 28) begin
        check_output("fill.notfull", 64'(full), 64'd0);
      end
    end
    check_output("fill.full", 64'(full), 64'd1);

    single_op("wrap100", 0, 1'b1, 32'd100, 1'b0, 0, 1'b1);
    check_output("wrap100.wdata", 64'(last_w_data), 64'd100);
    single_op("wrap101", 1, 1'b1, 32'd101, 1'b0, 1, 1'b1);
    single_op("gone7", 0, 1'b0, 32'd7, 1'b0, DEPTH - 1, 1'b0);
    single_op("gone5", 1, 1'b0, 32'd5, 1'b0, DEPTH - 1, 1'b0);
    single_op("hit100", 0, 1'b0, 32'd100, 1'b1, 0, 1'b0);
    check_output("wrap.full", 64'(full), 64'd1);

    @(negedge clk);
    apply_stimulus(0, 1'b1, 32'd55);
    k     = 0;
    wseen = 1'b0;
    while (!wseen && (k < 10)) begin
      @(negedge clk);
      k++;
      if (cam_write === 1'b1) begin
        wseen = 1'b1;
      end
    end
    check_output("midrst.write_seen", 64'(wseen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst.resp_valid", 64'(resp_valid), 64'd0);
    check_output("midrst.cam_write", 64'(cam_write), 64'd0);
    check_output("midrst.cam_search", 64'(cam_search), 64'd0);
    check_output("midrst.full", 64'(full), 64'd0);
    check_output("midrst.resp_hit", 64'(resp_hit), 64'd0);
    check_output("midrst.resp_index", 64'(resp_index), 64'd0);
    check_output("midrst.resp_evict", 64'(resp_evict), 64'd0);
    req = '0;
    rst = 1'b0;
    @(negedge clk);
    check_output("postrst.resp_valid", 64'(resp_valid), 64'd0);

    single_op("reins55", 0, 1'b1, 32'd55, 1'b0, 0, 1'b0);
    check_output("reins55.widx", 64'(last_w_idx), 64'd0);
    check_output("reins55.wdata", 64'(last_w_data), 64'd55);
    check_output("reins55.full", 64'(full), 64'd0);
    check_output("no_overlap", 64'(overlap_seen), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
